dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder side of the MEM-stage data-memory interface: accepts one load/store request at a time
//  and returns read data or store completion after a fixed, parameterised access latency.
//  Replaces the single-cycle RAM in the ldst path so the pipeline can be exercised against realistic latency.
//  Byte-addressed 16-bit words. Per-byte write enables. Errors for misaligned and out-of-range accesses.
// PARAMETERS
//  ADDR_W     16    request address width (byte address)
//  MEM_WORDS  1024  number of 16-bit words implemented; legal word index 0..MEM_WORDS-1
//  LATENCY    2     cycles from request handshake to rsp_valid; legal 1..15, elaboration error otherwise
// PORTS
//  clk        input   1       clock, rising edge
//  rst        input   1       asynchronous, active-low reset (asserted when 0)
//  req_valid  input   1       request present
//  req_ready  output  1       responder can accept request this cycle
//  req_addr   input   ADDR_W  byte address; bit 0 must be 0
//  req_wdata  input   16      store data
//  req_be     input   2       byte write enables; 2'b00=load, [0]=low byte, [1]=high byte
//  rsp_valid  output  1       response present
//  rsp_ready  input   1       requester accepts response
//  rsp_rdata  output  16      load data; 16'h0000 for stores and errors
//  rsp_err    output  1       access faulted (misaligned or out of range)
//  rsp_wr     output  1       response belongs to a store
// BEHAVIOUR
//  Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_wr=0, latency counter=0; req_ready=0 while rst==0.
//    Memory contents are not reset.
//  Handshake: a transfer occurs when valid&ready are high on a rising edge. rsp_* are stable while rsp_valid&~rsp_ready.
//  FSM IDLE: req_ready=1. On request handshake: capture addr/wdata/be; cnt<=LATENCY-1.
//    Go to RESP if LATENCY==1, otherwise go to BUSY.
//  FSM BUSY: req_ready=0; cnt decrements each cycle; when cnt==1 the access executes and the state moves to RESP.
//    Net effect: rsp_valid rises exactly LATENCY cycles after the request handshake.
//  Access execute (the edge entering RESP): err = addr[0] | (addr[ADDR_W-1:1] >= MEM_WORDS).
//    On err: no write, rdata=0. Otherwise a store writes only the enabled bytes, and a load registers the full word.
//  FSM RESP: rsp_valid=1. req_ready = rsp_ready (bypass): a response handshake and a new request may occur in the
//    same cycle. That new request behaves as if accepted in IDLE, and rsp_valid drops for >=1 cycle when LATENCY>1.
//    Response handshake with no new request -> IDLE.
//  Store followed by a load to the same address must return the new data (write commits before the next access).
//  Reset mid-operation: any pending request is dropped. A store still in BUSY is never written.
//    A store already in RESP has already been committed.
//  Counter width: 4 bits. No wrap, because cnt is only reloaded in IDLE/RESP.
// STRUCTURE
//  dmem_pkg: state enum {IDLE,BUSY,RESP}; BE_LOAD=2'b00, BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11;
//    function word_index(addr).
//  Sub-module dmem_array: MEM_WORDS x 16 storage, synchronous write with 2-bit byte enable, synchronous read, no reset.
//  Top level: FSM, latency counter, request capture registers, error check, response registers.
// TESTING
//  1. LATENCY=2, store addr 16'h0010 data 16'hBEEF be=11, then load 16'h0010.
//     Expected: store response has rsp_wr=1, err=0. Load response has rdata=16'hBEEF, valid 2 cycles after accept.
//  2. Mem at 16'h0020 = 16'h1234. Store be=01 data 16'h00AA, then load.
//     Expected: 16'h12AA. Then be=10 data 16'h5500, then load. Expected: 16'h55AA.
//  3. Load addr 16'h0021 (misaligned), then load 16'h0800 with MEM_WORDS=1024.
//     Expected: both give rsp_err=1, rdata=0. A later load of a valid address shows memory unchanged.
//  4. Hold rsp_ready=0 for 5 cycles in RESP.
//     Expected: rsp_valid/rdata stable and req_ready=0. Then raise rsp_ready together with a new req_valid.
//     Expected: both handshakes occur in the same cycle, and the next response arrives LATENCY cycles later.
//  5. Assert rst low while a store is in BUSY (LATENCY=4).
//     Expected: outputs return to reset values asynchronously. A later load of that address returns the old data.
//  6. LATENCY=1 back-to-back loads with rsp_ready=1.
//     Expected: one response per cycle, rsp_valid continuously high, data in request order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [1:0] BE_LOAD = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  localparam int CNT_W = 4;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 16-bit word storage with per-byte write enables and a registered read port; contents are not reset.
module dmem_array #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem [WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 2; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Read only on a load so the response word stays put while the requester stalls.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding request, response after a fixed LATENCY.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [15:0]       req_wdata_i,
  input  logic [1:0]        req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [15:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_wr_o
);

  localparam int              AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wdata_q;
  logic [1:0]         be_q;
  logic               rsp_err_q, rsp_wr_q, rd_sel_q;

  logic               accept, exec, err, we, re;
  logic [ADDR_W-1:0]  exec_addr;
  logic [15:0]        exec_wdata, arr_rdata;
  logic [1:0]         exec_be;
  logic [31:0]        wi;
  logic [AW-1:0]      idx;

  assign req_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o;

  // With LATENCY==1 the access executes on the accept edge using the live request.
  assign exec       = ((state_q == BUSY) && (cnt_q == 4'd1)) || (accept && (LATENCY == 1));
  assign exec_addr  = (state_q == BUSY) ? addr_q  : req_addr_i;
  assign exec_wdata = (state_q == BUSY) ? wdata_q : req_wdata_i;
  assign exec_be    = (state_q == BUSY) ? be_q    : req_be_i;

  assign wi  = word_index(32'(exec_addr));
  assign err = exec_addr[0] | (wi >= 32'(MEM_WORDS));
  assign idx = wi[AW-1:0];
  assign we  = exec & ~err & (exec_be != BE_LOAD);
  assign re  = exec & ~err & (exec_be == BE_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (accept) begin
            cnt_d   = CNT_LOAD;
            state_d = (LATENCY == 1) ? RESP : BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= BE_LOAD;
      rsp_err_q <= 1'b0;
      rsp_wr_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
      if (exec) begin
        rsp_err_q <= err;
        rsp_wr_q  <= (exec_be != BE_LOAD);
        rd_sel_q  <= ~err & (exec_be == BE_LOAD);
      end
    end
  end

  dmem_array #(.WORDS(MEM_WORDS), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .re_i    (re),
    .be_i    (exec_be),
    .addr_i  (idx),
    .wdata_i (exec_wdata),
    .rdata_o (arr_rdata)
  );

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rd_sel_q ? arr_rdata : 16'h0000;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_wr_o    = rsp_wr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) checked against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic [1:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        rsp_wr    [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W(16), .MEM_WORDS(1024), .LATENCY((g == 0) ? 2 : ((g == 1) ? 4 : 1))
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
      .req_addr_i(req_addr[g]), .req_wdata_i(req_wdata[g]), .req_be_i(req_be[g]),
      .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
      .rsp_rdata_o(rsp_rdata[g]), .rsp_err_o(rsp_err[g]), .rsp_wr_o(rsp_wr[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: memory is an array of words; faults neither read nor write.
  task automatic model(input int k, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                       output logic [15:0] rd, output logic er, output logic wr);
    int w;
    w  = int'(a) / 2;
    er = (a % 2 != 0) || (w >= 1024);
    wr = (be != 2'b00);
    rd = 16'h0000;
    if (!er) begin
      if (be == 2'b00) rd = mdl[k][w];
      else begin
        if (be[0]) mdl[k][w][7:0]  = wd[7:0];
        if (be[1]) mdl[k][w][15:8] = wd[15:8];
      end
    end
  endtask

  // One full transaction from a negedge: accept, latency, response fields, stall stability, retire.
  task automatic txn(input int k, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                     input int stall, input logic [15:0] erd, input logic eer, input logic ewr,
                     input string tag);
    int n, cyc;
    req_addr[k] = a; req_wdata[k] = wd; req_be[k] = be;
    req_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check($sformatf("%s accept", tag), 32'(n < 50), 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid[k] = 1'b0;
    cyc = 1;
    while (rsp_valid[k] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check($sformatf("%s latency", tag), 32'(cyc), 32'(lat_of(k)));
    check($sformatf("%s rdata", tag), 32'(rsp_rdata[k]), 32'(erd));
    check($sformatf("%s err", tag), 32'(rsp_err[k]), 32'(eer));
    check($sformatf("%s wr", tag), 32'(rsp_wr[k]), 32'(ewr));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check($sformatf("%s stall valid", tag), 32'(rsp_valid[k]), 32'd1);
      check($sformatf("%s stall rdata", tag), 32'(rsp_rdata[k]), 32'(erd));
      check($sformatf("%s stall ready", tag), 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready[k] = 1'b0;
    check($sformatf("%s retire", tag), 32'(rsp_valid[k]), 32'd0);
  endtask

  // Convenience: expected values from the model.
  task automatic mtxn(input int k, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                      input int stall, input string tag);
    logic [15:0] rd; logic er, wr;
    model(k, a, wd, be, rd, er, wr);
    txn(k, a, wd, be, stall, rd, er, wr, tag);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          stall;
    logic [15:0] rd;
    logic        er;
    logic        wr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd; logic er, wr;
    int cyc;

    tbl[0]  = '{16'h0010, 16'hBEEF, 2'b11, 0, 16'h0000, 1'b0, 1'b1};
    tbl[1]  = '{16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF, 1'b0, 1'b0};
    tbl[2]  = '{16'h0020, 16'h1234, 2'b11, 0, 16'h0000, 1'b0, 1'b1};
    tbl[3]  = '{16'h0020, 16'h00AA, 2'b01, 2, 16'h0000, 1'b0, 1'b1};
    tbl[4]  = '{16'h0020, 16'h0000, 2'b00, 0, 16'h12AA, 1'b0, 1'b0};
    tbl[5]  = '{16'h0020, 16'h5500, 2'b10, 1, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{16'h0020, 16'h0000, 2'b00, 0, 16'h55AA, 1'b0, 1'b0};
    tbl[7]  = '{16'h0021, 16'h0000, 2'b00, 1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0800, 16'h0000, 2'b00, 0, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{16'h0021, 16'hFFFF, 2'b11, 0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{16'h0800, 16'hFFFF, 2'b11, 0, 16'h0000, 1'b1, 1'b1};
    tbl[11] = '{16'h0020, 16'h0000, 2'b00, 0, 16'h55AA, 1'b0, 1'b0};
    tbl[12] = '{16'h07FE, 16'hABCD, 2'b11, 0, 16'h0000, 1'b0, 1'b1};
    tbl[13] = '{16'h07FE, 16'h0000, 2'b00, 0, 16'hABCD, 1'b0, 1'b0};
    tbl[14] = '{16'hFFFE, 16'h0000, 2'b00, 0, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset valid %0d", k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("reset ready %0d", k), 32'(req_ready[k]), 32'd0);
      check($sformatf("reset rdata %0d", k), 32'(rsp_rdata[k]), 32'd0);
      check($sformatf("reset err %0d", k), 32'(rsp_err[k]), 32'd0);
      check($sformatf("reset wr %0d", k), 32'(rsp_wr[k]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", 32'(req_ready[0]), 32'd1);

    // Directed vectors on the LATENCY=2 instance; the model follows along for later phases.
    for (int i = 0; i < 15; i++) begin
      model(0, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, wr);
      txn(0, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].stall,
          tbl[i].rd, tbl[i].er, tbl[i].wr, $sformatf("vec%0d", i));
    end

    // Long stall, then response handshake and new request on the same edge.
    req_addr[0] = 16'h0010; req_be[0] = 2'b00; req_valid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_addr[0] = 16'h0020;
    cyc = 1;
    while (rsp_valid[0] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("bypass first latency", 32'(cyc), 32'd2);
    for (int s = 0; s < 5; s++) begin
      check("bypass stall valid", 32'(rsp_valid[0]), 32'd1);
      check("bypass stall rdata", 32'(rsp_rdata[0]), 32'hBEEF);
      check("bypass stall ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    #1 check("bypass ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); @(negedge clk);
    rsp_ready[0] = 1'b0; req_valid[0] = 1'b0;
    check("bypass gap", 32'(rsp_valid[0]), 32'd0);
    cyc = 1;
    while (rsp_valid[0] !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    check("bypass second latency", 32'(cyc), 32'd2);
    check("bypass second rdata", 32'(rsp_rdata[0]), 32'h55AA);
    rsp_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready[0] = 1'b0;

    // Reset while a store sits in BUSY on the LATENCY=4 instance.
    mtxn(1, 16'h0040, 16'h1111, 2'b11, 0, "rst prefill");
    req_addr[1] = 16'h0040; req_wdata[1] = 16'h2222; req_be[1] = 2'b11; req_valid[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(rsp_valid[1]), 32'd0);
    check("midrst ready", 32'(req_ready[1]), 32'd0);
    check("midrst wr", 32'(rsp_wr[1]), 32'd0);
    check("midrst err", 32'(rsp_err[1]), 32'd0);
    check("midrst rdata", 32'(rsp_rdata[1]), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1, 16'h0040, 16'h0000, 2'b00, 0, 16'h1111, 1'b0, 1'b0, "midrst old data");

    // Back-to-back loads on the LATENCY=1 instance.
    for (int i = 0; i < 4; i++)
      mtxn(2, 16'(16'h0200 + 2 * i), 16'(16'hA000 + 16'h0111 * i), 2'b11, 0, "b2b prefill");
    rsp_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[2] = 16'(16'h0200 + 2 * i); req_be[2] = 2'b00; req_valid[2] = 1'b1;
      #1 check("b2b ready", 32'(req_ready[2]), 32'd1);
      @(posedge clk); @(negedge clk);
      model(2, req_addr[2], 16'h0000, 2'b00, rd, er, wr);
      check("b2b valid", 32'(rsp_valid[2]), 32'd1);
      check("b2b rdata", 32'(rsp_rdata[2]), 32'(rd));
    end
    req_valid[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    rsp_ready[2] = 1'b0;
    check("b2b drain", 32'(rsp_valid[2]), 32'd0);

    // Random traffic against the model over a small pool plus faulting addresses.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 8; w++)
        mtxn(k, 16'(16'h0100 + 2 * w), 16'($urandom), 2'b11, 0, "pool fill");
    for (int i = 0; i < 60; i++) begin
      int k, r;
      logic [15:0] a;
      logic [1:0]  be;
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 16'(16'h0101 + 2 * $urandom_range(0, 7));
      else if (r == 1) a = 16'(16'hF000 + 2 * $urandom_range(0, 100));
      else             a = 16'(16'h0100 + 2 * $urandom_range(0, 7));
      be = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
      mtxn(k, a, 16'($urandom), be, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
